// File: rtl/bus_master_interface_if.sv
// Host-side request/response channel of the bus master.
// The master modport is the core/DMA side; the slave modport is the bus master block.
interface bus_master_interface_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output req_ready, rsp_valid, rsp_error, rsp_rdata
  );
endinterface

// File: rtl/bus_master_interface.sv
// Peripheral bus initiator: turns one host load/store into a strobed bus cycle
// with lane masks, alignment checks, read-data extension and a no-responder timeout.
module bus_master_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  bus_master_interface_if.slave  host,
  output logic [31:0]            o_addr_bus,
  inout  wire  [31:0]            io_data_bus,
  output logic                   o_rd_bus,
  output logic                   o_wr_bus,
  output logic [3:0]             o_data_mask_bus,
  input  wire                    i_fc_bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUS_READ,
    ST_BUS_WRITE,
    ST_RELEASE,
    ST_FAULT
  } state_t;

  state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic        r_req_ready, w_req_ready_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic        r_rsp_error, w_rsp_error_next;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_next;
  logic [31:0] r_addr, w_addr_next;
  logic [3:0]  r_mask, w_mask_next;
  logic        r_rd, w_rd_next;
  logic        r_wr, w_wr_next;
  logic [1:0]  r_size, w_size_next;
  logic        r_signed, w_signed_next;
  logic [31:0] r_wdata, w_wdata_next;

  logic        w_fc_done;
  logic        w_cnt_last;
  logic [2:0]  w_req_bytes;
  logic        w_req_bad;
  logic [3:0]  w_req_mask;
  logic [31:0] w_req_wdata;
  logic [31:0] w_rd_ext;

  // Only a driven 1 counts as complete; floating or unknown means keep waiting.
  assign w_fc_done  = (i_fc_bus === 1'b1);
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign io_data_bus     = r_wr ? r_wdata : {32{1'bz}};
  assign o_addr_bus      = r_addr;
  assign o_rd_bus        = r_rd;
  assign o_wr_bus        = r_wr;
  assign o_data_mask_bus = r_mask;

  assign host.req_ready = r_req_ready;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_error = r_rsp_error;
  assign host.rsp_rdata = r_rsp_rdata;

  // Size decode for the incoming request: byte count, lane mask, zeroed store lanes.
  always_comb begin
    w_req_bytes = 3'd4;
    w_req_mask  = 4'b1111;
    w_req_wdata = host.req_wdata;
    case (host.req_size)
      2'd0: begin
        w_req_bytes = 3'd1;
        w_req_mask  = 4'b0001;
        w_req_wdata = {24'd0, host.req_wdata[7:0]};
      end
      2'd1: begin
        w_req_bytes = 3'd2;
        w_req_mask  = 4'b0011;
        w_req_wdata = {16'd0, host.req_wdata[15:0]};
      end
      default: ;
    endcase
    w_req_bad = (host.req_size == 2'd3) ||
                ((3'({1'b0, host.req_addr[1:0]}) + w_req_bytes) > 3'd4);
  end

  // Responder returns data LSB-aligned; extend the active lanes per size/sign.
  always_comb begin
    w_rd_ext = io_data_bus;
    case (r_size)
      2'd0: w_rd_ext = r_signed ? {{24{io_data_bus[7]}}, io_data_bus[7:0]}
                                : {24'd0, io_data_bus[7:0]};
      2'd1: w_rd_ext = r_signed ? {{16{io_data_bus[15]}}, io_data_bus[15:0]}
                                : {16'd0, io_data_bus[15:0]};
      default: w_rd_ext = io_data_bus;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_req_ready_next = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_rsp_error_next = 1'b0;
    w_rsp_rdata_next = 32'd0;
    w_addr_next      = r_addr;
    w_mask_next      = r_mask;
    w_rd_next        = 1'b0;
    w_wr_next        = 1'b0;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_wdata_next     = r_wdata;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_next = 1'b1;
        if (host.req_valid && r_req_ready) begin
          w_req_ready_next = 1'b0;
          w_cnt_next       = '0;
          w_size_next      = host.req_size;
          w_signed_next    = host.req_signed;
          if (w_req_bad) begin
            w_state_next     = ST_FAULT;
            w_rsp_valid_next = 1'b1;
            w_rsp_error_next = 1'b1;
          end else begin
            w_addr_next  = host.req_addr;
            w_mask_next  = w_req_mask;
            w_wdata_next = w_req_wdata;
            if (host.req_write) begin
              w_state_next = ST_BUS_WRITE;
              w_wr_next    = 1'b1;
            end else begin
              w_state_next = ST_BUS_READ;
              w_rd_next    = 1'b1;
            end
          end
        end
      end

      ST_BUS_READ, ST_BUS_WRITE: begin
        if (w_fc_done) begin
          w_state_next     = ST_RELEASE;
          w_cnt_next       = '0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = (r_state == ST_BUS_READ) ? w_rd_ext : 32'd0;
        end else if (w_cnt_last) begin
          w_state_next     = ST_RELEASE;
          w_cnt_next       = '0;
          w_rsp_valid_next = 1'b1;
          w_rsp_error_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
          w_rd_next  = (r_state == ST_BUS_READ);
          w_wr_next  = (r_state == ST_BUS_WRITE);
        end
      end

      // Strobes low, address held until the responder lets go of fc_bus.
      ST_RELEASE: begin
        if (!w_fc_done || w_cnt_last) begin
          w_state_next     = ST_IDLE;
          w_cnt_next       = '0;
          w_req_ready_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      ST_FAULT: begin
        w_state_next     = ST_IDLE;
        w_req_ready_next = 1'b1;
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_cnt_next       = '0;
        w_req_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_addr      <= 32'd0;
      r_mask      <= 4'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_wdata     <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_error <= w_rsp_error_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_addr      <= w_addr_next;
      r_mask      <= w_mask_next;
      r_rd        <= w_rd_next;
      r_wr        <= w_wr_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_wdata     <= w_wdata_next;
    end
  end

endmodule

// File: tb/tb_bus_master_interface.sv
// Scoreboard bench for bus_master_interface with a memory-backed responder at 0x1000-0x10FF
// that can answer combinationally or through a registered fc.
module tb_bus_master_interface;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_interface_if bus_if ();

  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus, wr_bus;
  logic [3:0]  data_mask_bus;
  wire         fc_bus;

  bus_master_interface #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (bus_if.slave),
    .o_addr_bus      (addr_bus),
    .io_data_bus     (data_bus),
    .o_rd_bus        (rd_bus),
    .o_wr_bus        (wr_bus),
    .o_data_mask_bus (data_mask_bus),
    .i_fc_bus        (fc_bus)
  );

  // Responder model
  logic [31:0] mem [64] = '{default: 32'd0};
  logic        resp_reg = 1'b0;
  logic        fc_r = 1'b0;
  logic        mapped;
  logic [31:0] rd_word;

  assign mapped   = (addr_bus[31:8] == 24'h000010);
  assign rd_word  = mem[addr_bus[7:2]] >> {addr_bus[1:0], 3'b000};
  assign data_bus = (rd_bus && mapped) ? rd_word : {32{1'bz}};
  assign fc_bus   = mapped ? (resp_reg ? fc_r : (rd_bus | wr_bus)) : 1'bz;

  always @(posedge clk) begin
    logic [31:0] w;
    fc_r <= rd_bus | wr_bus;
    if (wr_bus && mapped) begin
      w = mem[addr_bus[7:2]];
      for (int i = 0; i < 4; i++)
        if (data_mask_bus[i] && (int'(addr_bus[1:0]) + i < 4))
          w[8*(int'(addr_bus[1:0]) + i) +: 8] = data_bus[8*i +: 8];
      mem[addr_bus[7:2]] <= w;
    end
  end

  // Scoreboard
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   unexpected = 0;
  int   rd_total = 0, wr_total = 0;
  logic [31:0] last_wdata = 32'd0;
  logic [3:0]  last_wmask = 4'd0, last_rmask = 4'd0;
  logic        both_seen = 1'b0, rdy_rsp_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    else n_pass++;
  endtask

  // Monitor: bus activity bookkeeping and response checking
  always @(negedge clk) begin
    exp_t e;
    if (rd_bus) begin rd_total++; last_rmask = data_mask_bus; end
    if (wr_bus) begin wr_total++; last_wdata = data_bus; last_wmask = data_mask_bus; end
    if (rd_bus && wr_bus) both_seen = 1'b1;
    if (bus_if.req_ready && bus_if.rsp_valid) rdy_rsp_seen = 1'b1;
    if (bus_if.rsp_valid) begin
      if (sb_q.size() == 0) begin
        unexpected++;
        $display("FAIL unexpected_rsp: rsp_valid at cycle %0d with no outstanding request", cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_err"},   32'(bus_if.rsp_error), 32'(e.err));
        check({e.name, "_rdata"}, bus_if.rsp_rdata, e.rdata);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  int rd0, wr0;

  // Issue one request from a negedge; returns at the negedge where req_ready comes back.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input int lat, input int rdy_lat,
                       input string name);
    int cyc0, n;
    exp_t e;
    n = 0;
    while (!bus_if.req_ready && n < 100) begin @(negedge clk); n++; end
    rd0 = rd_total;
    wr0 = wr_total;
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = wr;
    bus_if.req_addr   = addr;
    bus_if.req_size   = size;
    bus_if.req_signed = sgn;
    bus_if.req_wdata  = wdata;
    cyc0 = cyc;
    e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc0 + lat; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    n = 0;
    while (!bus_if.req_ready && n < 100) begin @(negedge clk); n++; end
    check({name, "_ready_cycle"}, 32'(cyc - cyc0), 32'(rdy_lat));
    check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_size   = 2'd0;
    bus_if.req_signed = 1'b0;
    bus_if.req_wdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_ready",     32'(bus_if.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("reset_strobes",   32'({rd_bus, wr_bus}), 32'd0);
    check("reset_addr",      addr_bus, 32'd0);
    check("reset_mask",      32'(data_mask_bus), 32'd0);

    // Registered responder: word store, strobe two cycles
    resp_reg = 1'b1;
    issue(1'b1, 32'h1004, 2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0, 3, 5, "st_word");
    check("st_word_wr_len", 32'(wr_total - wr0), 32'd2);
    check("st_word_mask",   32'(last_wmask), 32'hF);
    check("st_word_data",   last_wdata, 32'h11223344);

    // Combinational responder from here on
    resp_reg = 1'b0;
    issue(1'b0, 32'h1004, 2'd2, 1'b0, 32'h0, 1'b0, 32'h11223344, 2, 3, "ld_word");
    check("ld_word_rd_len", 32'(rd_total - rd0), 32'd1);

    issue(1'b1, 32'h1007, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 32'h0, 2, 3, "st_byte");
    check("st_byte_mask", 32'(last_wmask), 32'h1);
    check("st_byte_data", last_wdata, 32'h00000080);

    issue(1'b0, 32'h1007, 2'd0, 1'b1, 32'h0, 1'b0, 32'hFFFFFF80, 2, 3, "ld_byte_s");
    check("ld_byte_s_mask", 32'(last_rmask), 32'h1);
    issue(1'b0, 32'h1007, 2'd0, 1'b0, 32'h0, 1'b0, 32'h00000080, 2, 3, "ld_byte_u");

    issue(1'b1, 32'h1002, 2'd1, 1'b0, 32'hABCD1234, 1'b0, 32'h0, 2, 3, "st_half");
    check("st_half_mask", 32'(last_wmask), 32'h3);
    check("st_half_data", last_wdata, 32'h00001234);
    issue(1'b0, 32'h1002, 2'd1, 1'b0, 32'h0, 1'b0, 32'h00001234, 2, 3, "ld_half");
    // 0x1004 now holds 0x80223344; upper half 0x8022 sign-extends
    issue(1'b0, 32'h1006, 2'd1, 1'b1, 32'h0, 1'b0, 32'hFFFF8022, 2, 3, "ld_half_s");

    issue(1'b0, 32'h1001, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1, 2, "ld_misalign");
    check("ld_misalign_rd_len", 32'(rd_total - rd0), 32'd0);
    issue(1'b1, 32'h1003, 2'd1, 1'b0, 32'hFFFF, 1'b1, 32'h0, 1, 2, "st_misalign");
    check("st_misalign_wr_len", 32'(wr_total - wr0), 32'd0);
    issue(1'b0, 32'h1000, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1, 2, "ld_illegal");
    check("ld_illegal_rd_len", 32'(rd_total - rd0), 32'd0);

    // Unmapped: fc floats, strobe for the full timeout
    issue(1'b0, 32'h2000, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 17, 18, "ld_timeout");
    check("ld_timeout_rd_len", 32'(rd_total - rd0), 32'd16);

    // Reset during cycle 2 of a registered write; no response must follow
    resp_reg = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 32'h1008;
    bus_if.req_size  = 2'd2;
    bus_if.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("abort_wr_cycle1", 32'(wr_bus), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_strobes",   32'({rd_bus, wr_bus}), 32'd0);
    check("abort_ready",     32'(bus_if.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("abort_addr",      addr_bus, 32'd0);
    repeat (20) @(negedge clk);

    resp_reg = 1'b0;
    issue(1'b0, 32'h1004, 2'd2, 1'b0, 32'h0, 1'b0, 32'h80223344, 2, 3, "ld_after_rst");

    repeat (5) @(negedge clk);
    check("no_unexpected_rsp", 32'(unexpected), 32'd0);
    check("queue_empty",       32'(sb_q.size()), 32'd0);
    check("rd_wr_exclusive",   32'(both_seen), 32'd0);
    check("ready_vs_rsp",      32'(rdy_rsp_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
